aes_iter_cipher: RTL

Iterative, parametrised AES-128 engine. It succeeds the combinational decrypt core by supporting both encrypt and decrypt per block, selectable unrolling, and valid/ready handshakes. Round keys are expanded once per key load and stored, so decryption starts directly from round key 10. It sits between the host-side block FIFO and the output packer.

---
 rtl/aes_iter_cipher.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_iter_cipher.sv
// Iterative AES-128 encrypt/decrypt engine: key expanded once into 11 stored round keys,
// ROUNDS_PER_CYCLE rounds per clock. Define AES_ZEROIZE_EN to add the zeroize input.
module aes_iter_cipher #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_mode,
    output logic         busy
`ifdef AES_ZEROIZE_EN
    ,
    input  logic         zeroize
`endif
);

    localparam int NUM_ROUNDS = 10;
    localparam int NUM_STEPS  = NUM_ROUNDS / ROUNDS_PER_CYCLE;

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 5 && ROUNDS_PER_CYCLE != 10) begin : g_bad_rounds_per_cycle
        $error("aes_iter_cipher: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    typedef enum logic [1:0] {IDLE, KEYEXP, READY, RUN} fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        r    = 8'h01;
        base = a;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            r    = gf_mul(r, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    // byte i sits at [127-8i -: 8]; row r, column c is byte r+4c
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = prev;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    fsm_t         fsm;
    logic [127:0] rk [0:10];
    logic [127:0] blk;
    logic         blk_mode;
    logic [3:0]   round_cnt;
    logic [3:0]   key_cnt;
    logic         key_loaded;
    logic         zero_req;
    logic [127:0] round_state;
    logic [3:0]   round_idx;
    logic [127:0] next_rk;
    logic [3:0]   key_prev;

`ifdef AES_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    assign in_ready = (fsm == READY) && key_loaded && !out_valid && !key_valid;
    assign key_prev = key_cnt - 4'd1;
    assign next_rk  = key_step(rk[key_prev], rcon(key_cnt));

    // round_idx counts cipher rounds 1..10 in the order they are applied for either direction
    always_comb begin
        round_state = blk;
        round_idx   = 4'd0;
        for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
            round_idx = 4'(int'(round_cnt) * ROUNDS_PER_CYCLE + i + 1);
            if (!blk_mode) begin
                round_state = sub_shift(round_state);
                if (round_idx != 4'd10) round_state = mix_columns(round_state);
                round_state = round_state ^ rk[round_idx];
            end else begin
                round_state = inv_shift_sub(round_state) ^ rk[4'd10 - round_idx];
                if (round_idx != 4'd10) round_state = inv_mix_columns(round_state);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= IDLE;
            key_loaded <= 1'b0;
            for (int i = 0; i < 11; i++) rk[i] <= '0;
            blk        <= '0;
            blk_mode   <= 1'b0;
            round_cnt  <= 4'd0;
            key_cnt    <= 4'd0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_mode   <= 1'b0;
            busy       <= 1'b0;
            key_ready  <= 1'b1;
        end else if (zero_req) begin
            fsm        <= IDLE;
            key_loaded <= 1'b0;
            for (int i = 0; i < 11; i++) rk[i] <= '0;
            blk        <= '0;
            blk_mode   <= 1'b0;
            round_cnt  <= 4'd0;
            key_cnt    <= 4'd0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_mode   <= 1'b0;
            busy       <= 1'b0;
            key_ready  <= 1'b1;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (fsm)
                IDLE, READY: begin
                    if (key_valid) begin
                        rk[0]      <= key_in;
                        key_cnt    <= 4'd1;
                        key_loaded <= 1'b0;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        fsm        <= KEYEXP;
                    end else if (in_valid && in_ready) begin
                        blk       <= in_data ^ (in_mode ? rk[10] : rk[0]);
                        blk_mode  <= in_mode;
                        round_cnt <= 4'd0;
                        key_ready <= 1'b0;
                        busy      <= 1'b1;
                        fsm       <= RUN;
                    end
                end
                KEYEXP: begin
                    rk[key_cnt] <= next_rk;
                    if (key_cnt == 4'd10) begin
                        key_loaded <= 1'b1;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        fsm        <= READY;
                    end else begin
                        key_cnt <= key_cnt + 4'd1;
                    end
                end
                RUN: begin
                    blk <= round_state;
                    if (round_cnt == 4'(NUM_STEPS - 1)) begin
                        out_data  <= round_state;
                        out_mode  <= blk_mode;
                        out_valid <= 1'b1;
                        key_ready <= 1'b1;
                        busy      <= 1'b0;
                        fsm       <= READY;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule
